// File: rtl/ppu_mem_pkg.sv
// Shared definitions for the PPU VRAM controller: mirror modes, address map, decode helpers.
package ppu_mem_pkg;
  localparam logic [2:0] MIRROR_HORIZ    = 3'd0;
  localparam logic [2:0] MIRROR_VERT     = 3'd1;
  localparam logic [2:0] MIRROR_SINGLE_A = 3'd2;
  localparam logic [2:0] MIRROR_SINGLE_B = 3'd3;
  localparam logic [2:0] MIRROR_FOUR     = 3'd4;

  localparam logic [13:0] PAL_BASE = 14'h3F00;
  localparam logic [13:0] NT_BASE  = 14'h2000;

  typedef enum logic [1:0] {PORT_NONE, PORT_A, PORT_B} port_sel_e;
  typedef enum logic [1:0] {REG_PAT, REG_NT, REG_PAL} region_e;

  function automatic region_e decode(input logic [13:0] addr);
    if (addr < NT_BASE)        return REG_PAT;
    else if (addr >= PAL_BASE) return REG_PAL;
    else                       return REG_NT;
  endfunction

  // Sprite backdrop entries 0x10/14/18/1C share storage with 0x00/04/08/0C.
  function automatic logic [4:0] pal_index(input logic [13:0] addr);
    logic [4:0] idx;
    idx = addr[4:0];
    if (idx[1:0] == 2'b00) idx[4] = 1'b0;
    return idx;
  endfunction
endpackage

// File: rtl/ppu_nt_addr_map.sv
// Maps a name table address (table select + offset) onto physical NT RAM per mirror mode.
module ppu_nt_addr_map
  import ppu_mem_pkg::*;
#(
  parameter int NT_ADDR_WIDTH = 11
) (
  input  logic [2:0]               mode,
  input  logic [11:0]              addr,
  output logic [NT_ADDR_WIDTH-1:0] nt_addr
);
  logic [1:0] t;
  logic [9:0] off;
  logic [1:0] page;

  always_comb begin
    t   = addr[11:10];
    off = addr[9:0];
    case (mode)
      MIRROR_VERT:     page = {1'b0, t[0]};
      MIRROR_SINGLE_A: page = 2'b00;
      MIRROR_SINGLE_B: page = 2'b01;
      // Four-screen needs 4 KB of NT RAM; with less it degrades to horizontal.
      MIRROR_FOUR:     page = (NT_ADDR_WIDTH >= 12) ? t : {1'b0, t[1]};
      default:         page = {1'b0, t[1]};
    endcase
    nt_addr = NT_ADDR_WIDTH'({page, off});
  end
endmodule

// File: rtl/single_port_ram_sync.sv
// Single-port synchronous block RAM with registered read (1-cycle latency).
module single_port_ram_sync #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM controller: arbitrates render port A and host port B onto pattern/NT RAMs and palette.
module ppu_vram_ctrl
  import ppu_mem_pkg::*;
#(
  parameter int CHR_ADDR_WIDTH = 13,
  parameter int NT_ADDR_WIDTH  = 11,
  parameter int CHR_RAM        = 1,
  parameter int STARVE_LIMIT   = 4,
  parameter int MIRROR_DEFAULT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_mirror,
  output logic [2:0]  mirror,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [13:0] a_addr,
  input  logic [7:0]  a_din,
  output logic        a_ack,
  output logic        a_rvalid,
  output logic [7:0]  a_dout,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [13:0] b_addr,
  input  logic [7:0]  b_din,
  output logic        b_ack,
  output logic        b_rvalid,
  output logic [7:0]  b_dout
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]            starve_cnt;
  logic                     b_force;
  port_sel_e                sel;
  logic                     sel_wr;
  logic [13:0]              sel_addr;
  logic [7:0]               sel_din;
  region_e                  region, src_q;
  logic [1:0]               rv_q;
  logic [7:0]               a_hold, b_hold, rd_data, pat_q, nt_q, pal_q;
  logic                     pat_we, nt_we, pal_we;
  logic [4:0]               pal_idx;
  logic [NT_ADDR_WIDTH-1:0] nt_addr;
  logic [7:0]               pal [32];

  // B only overtakes A once it has been refused STARVE_LIMIT cycles in a row.
  assign b_force = b_req && (starve_cnt == SW'(STARVE_LIMIT));
  assign a_ack   = !rst && a_req && !b_force;
  assign b_ack   = !rst && b_req && (!a_req || b_force);

  always_comb begin
    sel      = PORT_NONE;
    sel_wr   = 1'b0;
    sel_addr = a_addr;
    sel_din  = a_din;
    if (a_ack)      sel = PORT_A;
    else if (b_ack) sel = PORT_B;
    if (sel == PORT_B) begin
      sel_wr   = b_wr;
      sel_addr = b_addr;
      sel_din  = b_din;
    end else if (sel == PORT_A) begin
      sel_wr = a_wr;
    end
  end

  assign region  = decode(sel_addr);
  assign pal_idx = pal_index(sel_addr);
  assign pat_we  = (sel != PORT_NONE) && sel_wr && (region == REG_PAT) && (CHR_RAM != 0);
  assign nt_we   = (sel != PORT_NONE) && sel_wr && (region == REG_NT);
  assign pal_we  = (sel != PORT_NONE) && sel_wr && (region == REG_PAL);

  ppu_nt_addr_map #(.NT_ADDR_WIDTH(NT_ADDR_WIDTH)) u_nt_map (
    .mode(mirror), .addr(sel_addr[11:0]), .nt_addr(nt_addr)
  );

  single_port_ram_sync #(.ADDR_WIDTH(CHR_ADDR_WIDTH), .DATA_WIDTH(8)) u_pat_ram (
    .clk(clk), .we(pat_we), .addr(sel_addr[CHR_ADDR_WIDTH-1:0]), .din(sel_din), .dout(pat_q)
  );

  single_port_ram_sync #(.ADDR_WIDTH(NT_ADDR_WIDTH), .DATA_WIDTH(8)) u_nt_ram (
    .clk(clk), .we(nt_we), .addr(nt_addr), .din(sel_din), .dout(nt_q)
  );

  // Palette read is registered so all three regions share the same latency.
  always_ff @(posedge clk) begin
    if (pal_we) pal[pal_idx] <= sel_din;
    pal_q <= pal[pal_idx];
  end

  always_comb begin
    case (src_q)
      REG_NT:  rd_data = nt_q;
      REG_PAL: rd_data = pal_q;
      default: rd_data = pat_q;
    endcase
  end

  assign a_rvalid = rv_q[0] && !rst;
  assign b_rvalid = rv_q[1] && !rst;
  assign a_dout   = a_rvalid ? rd_data : a_hold;
  assign b_dout   = b_rvalid ? rd_data : b_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      mirror     <= 3'(MIRROR_DEFAULT);
      starve_cnt <= '0;
      rv_q       <= '0;
      src_q      <= REG_PAT;
      a_hold     <= 8'h00;
      b_hold     <= 8'h00;
    end else begin
      if (cfg_wr && (cfg_mirror <= MIRROR_FOUR)) mirror <= cfg_mirror;
      if (!b_req || b_ack)                        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT))   starve_cnt <= starve_cnt + 1'b1;
      rv_q  <= {b_ack && !b_wr, a_ack && !a_wr};
      src_q <= region;
      if (a_rvalid) a_hold <= rd_data;
      if (b_rvalid) b_hold <= rd_data;
    end
  end
endmodule
